// File: rtl/uio_sched_pkg.sv
// uio_sched_pkg
//   Shared types and constants for the uio pin-bank scheduler.
//   state_t : scheduler FSM states (IDLE, TURN, XFER)
//   BYTE_W  : width of one transfer on the uio bank
//   OE_OUT  : pad enable value when the tile drives the bank
//   OE_IN   : pad enable value when the bank is an input
package uio_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2
    } state_t;

    localparam int         BYTE_W = 8;
    localparam logic [7:0] OE_OUT = 8'hFF;
    localparam logic [7:0] OE_IN  = 8'h00;

endpackage

// File: rtl/uio_bus_sched_rr_pick.sv
// rr_pick
//   Combinational round-robin priority select. Searches elig_i upward
//   starting at ptr_i+1, wrapping modulo N, and returns the first set index.
//   Ports:
//     elig_i  [N-1:0]  eligible requesters
//     ptr_i   [PW-1:0] index of the most recent winner (must be < N)
//     found_o          at least one requester is eligible
//     idx_o   [PW-1:0] winning index (0 when found_o is low)
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  elig_i,
    input  logic [PW-1:0] ptr_i,
    output logic          found_o,
    output logic [PW-1:0] idx_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             off;
    int             sum;

    always_comb begin
        // Rotate so that bit j of rot corresponds to index (ptr+1+j) mod N;
        // the lowest set bit of rot is then the round-robin winner.
        dbl = {elig_i, elig_i} >> (int'(ptr_i) + 1);
        rot = dbl[N-1:0];
        off = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = j;
            end
        end
        sum = int'(ptr_i) + 1 + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        found_o = |elig_i;
        idx_o   = found_o ? PW'(sum) : '0;
    end

endmodule

// File: rtl/uio_bus_sched.sv
// uio_bus_sched
//   Round-robin scheduler sharing the 8-bit bidirectional uio pin bank
//   between NREQ requesters. Each grant is a single-byte write (drive the
//   pads) or read (sample the pads). Turnaround cycles with the pads
//   released are inserted whenever the bus direction changes.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     ena                   tile enable; low blocks new grants and parks
//                           the bus as input
//     req/req_wr/req_wdata  per-requester request, direction, write byte
//     done                  one-hot completion pulse, one cycle
//     rdata                 last read byte, valid while done pulses a read
//     uio_in/out/oe         pad input, pad output, pad enable
//   All outputs come straight from registers.
module uio_bus_sched
    import uio_sched_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int TURN_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [NREQ*BYTE_W-1:0] req_wdata,
    output logic [NREQ-1:0]        done,
    output logic [BYTE_W-1:0]      rdata,
    input  logic [BYTE_W-1:0]      uio_in,
    output logic [BYTE_W-1:0]      uio_out,
    output logic [BYTE_W-1:0]      uio_oe
);

    localparam int            PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] PTR_RST   = PW'(NREQ - 1);
    localparam logic [3:0]    TURN_LOAD = 4'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    state_t              state_q, state_d;
    logic                dir_q, dir_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [PW-1:0]       idx_q, idx_d;
    logic                wr_q, wr_d;
    logic [BYTE_W-1:0]   wdata_q, wdata_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [BYTE_W-1:0]   rdata_q, rdata_d;
    logic [BYTE_W-1:0]   out_q, out_d;
    logic [BYTE_W-1:0]   oe_q, oe_d;

    logic [NREQ-1:0]     elig;
    logic                found;
    logic [PW-1:0]       pick_idx;
    logic                win_wr;
    logic [BYTE_W-1:0]   win_data;

    // A requester whose done is pulsing this cycle usually still has req
    // high; masking it keeps it from being re-granted for the same request.
    assign elig = req & ~done_q;

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        win_wr   = 1'b0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == PW'(i)) begin
                win_wr   = req_wr[i];
                win_data = req_wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        done_d  = '0;
        rdata_d = rdata_q;
        out_d   = out_q;
        oe_d    = oe_q;

        case (state_q)
            IDLE: begin
                if (!ena) begin
                    dir_d = 1'b0;
                end else if (found) begin
                    idx_d   = pick_idx;
                    wr_d    = win_wr;
                    wdata_d = win_data;
                    ptr_d   = pick_idx;
                    if ((win_wr == dir_q) || (TURN_CYCLES == 0)) begin
                        state_d = XFER;
                    end else begin
                        state_d = TURN;
                        cnt_d   = TURN_LOAD;
                    end
                end
            end
            TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            XFER: begin
                state_d = IDLE;
                for (int i = 0; i < NREQ; i++) begin
                    done_d[i] = (idx_q == PW'(i));
                end
                if (!wr_q) begin
                    rdata_d = uio_in;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pad registers are loaded from the state being entered so that
        // the pads already show the right value in that state's cycle.
        case (state_d)
            TURN: begin
                oe_d = OE_IN;
            end
            XFER: begin
                dir_d = wr_d;
                oe_d  = wr_d ? OE_OUT : OE_IN;
                if (wr_d) begin
                    out_d = wdata_d;
                end
            end
            default: begin
                oe_d = dir_d ? OE_OUT : OE_IN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            ptr_q   <= PTR_RST;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            out_q   <= '0;
            oe_q    <= OE_IN;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
        end
    end

    assign done    = done_q;
    assign rdata   = rdata_q;
    assign uio_out = out_q;
    assign uio_oe  = oe_q;

endmodule

// File: tb/tb_uio_bus_sched.sv
// tb_uio_bus_sched
//   Directed bench for uio_bus_sched. Two instances share the stimulus:
//   dut uses TURN_CYCLES=1, dut3 uses TURN_CYCLES=3. Inputs change and
//   outputs are sampled on the falling clock edge.
module tb_uio_bus_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [2:0]  req;
    logic [2:0]  req_wr;
    logic [23:0] req_wdata;
    logic [7:0]  uio_in;

    logic [2:0]  done, done3;
    logic [7:0]  rdata, rdata3;
    logic [7:0]  uio_out, out3;
    logic [7:0]  uio_oe, oe3;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uio_bus_sched #(.NREQ(3), .TURN_CYCLES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req       (req),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .done      (done),
        .rdata     (rdata),
        .uio_in    (uio_in),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe)
    );

    uio_bus_sched #(.NREQ(3), .TURN_CYCLES(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req       (req),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .done      (done3),
        .rdata     (rdata3),
        .uio_in    (uio_in),
        .uio_out   (out3),
        .uio_oe    (oe3)
    );

    task automatic do_reset();
        rst_n     = 1'b0;
        ena       = 1'b1;
        req       = 3'b000;
        req_wr    = 3'b000;
        req_wdata = 24'h0;
        uio_in    = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            vectors++;
            if ({done, uio_oe, uio_out, rdata} !== 27'h0) begin
                miscompares++;
                $display("FAIL reset_idle k=%0d got done=%b oe=%h out=%h rdata=%h want all zero",
                         k, done, uio_oe, uio_out, rdata);
            end
            vectors++;
            if ({done3, oe3, out3, rdata3} !== 27'h0) begin
                miscompares++;
                $display("FAIL reset_idle3 k=%0d got done=%b oe=%h out=%h rdata=%h want all zero",
                         k, done3, oe3, out3, rdata3);
            end
        end
    endtask

    task automatic test_write_turn();
        do_reset();
        req       = 3'b001;
        req_wr    = 3'b001;
        req_wdata = 24'h0000A5;
        @(negedge clk);
        req = 3'b000;
        vectors++;
        if ({done, uio_oe} !== {3'b000, 8'h00}) begin
            miscompares++;
            $display("FAIL wr_turn got done=%b oe=%h want done=000 oe=00", done, uio_oe);
        end
        @(negedge clk);
        vectors++;
        if ({done, uio_oe, uio_out} !== {3'b000, 8'hFF, 8'hA5}) begin
            miscompares++;
            $display("FAIL wr_xfer got done=%b oe=%h out=%h want 000/FF/A5", done, uio_oe, uio_out);
        end
        @(negedge clk);
        vectors++;
        if ({done, uio_oe, uio_out} !== {3'b001, 8'hFF, 8'hA5}) begin
            miscompares++;
            $display("FAIL wr_done got done=%b oe=%h out=%h want 001/FF/A5", done, uio_oe, uio_out);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({done, uio_oe, uio_out} !== {3'b000, 8'hFF, 8'hA5}) begin
                miscompares++;
                $display("FAIL wr_park k=%0d got done=%b oe=%h out=%h want 000/FF/A5",
                         k, done, uio_oe, uio_out);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [18:0] exp_t [8];
        exp_t = '{{3'b000, 8'hFF, 8'h11}, {3'b001, 8'hFF, 8'h11},
                  {3'b000, 8'hFF, 8'h22}, {3'b010, 8'hFF, 8'h22},
                  {3'b000, 8'hFF, 8'h33}, {3'b100, 8'hFF, 8'h33},
                  {3'b000, 8'hFF, 8'h11}, {3'b001, 8'hFF, 8'h11}};
        do_reset();
        req       = 3'b111;
        req_wr    = 3'b111;
        req_wdata = 24'h332211;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if ({done, uio_oe, uio_out} !== exp_t[k]) begin
                miscompares++;
                $display("FAIL rr k=%0d got done=%b oe=%h out=%h want %h",
                         k, done, uio_oe, uio_out, exp_t[k]);
            end
        end
        req = 3'b000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({done, uio_oe, uio_out} !== {3'b000, 8'hFF, 8'h11}) begin
                miscompares++;
                $display("FAIL rr_quiet k=%0d got done=%b oe=%h out=%h want 000/FF/11",
                         k, done, uio_oe, uio_out);
            end
        end
    endtask

    task automatic test_turnaround();
        logic [26:0] exp_t [10];
        exp_t = '{{3'b000, 8'h00, 8'h00, 8'h00}, {3'b000, 8'h00, 8'h00, 8'h00},
                  {3'b000, 8'h00, 8'h00, 8'h00}, {3'b000, 8'hFF, 8'h5A, 8'h00},
                  {3'b001, 8'hFF, 8'h5A, 8'h00}, {3'b000, 8'h00, 8'h5A, 8'h00},
                  {3'b000, 8'h00, 8'h5A, 8'h00}, {3'b000, 8'h00, 8'h5A, 8'h00},
                  {3'b000, 8'h00, 8'h5A, 8'h00}, {3'b010, 8'h00, 8'h5A, 8'hC3}};
        do_reset();
        uio_in    = 8'hC3;
        req       = 3'b011;
        req_wr    = 3'b001;
        req_wdata = 24'h00005A;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) req[0] = 1'b0;
            if (k == 5) req[1] = 1'b0;
            vectors++;
            if ({done3, oe3, out3, rdata3} !== exp_t[k]) begin
                miscompares++;
                $display("FAIL turn3 k=%0d got done=%b oe=%h out=%h rdata=%h want %h",
                         k + 1, done3, oe3, out3, rdata3, exp_t[k]);
            end
        end
        uio_in = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({done3, rdata3} !== {3'b000, 8'hC3}) begin
                miscompares++;
                $display("FAIL rdata_hold k=%0d got done=%b rdata=%h want 000/C3", k, done3, rdata3);
            end
        end
    endtask

    task automatic test_ena_drop();
        do_reset();
        req       = 3'b001;
        req_wr    = 3'b001;
        req_wdata = 24'h000077;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({done, uio_oe, uio_out} !== {3'b000, 8'hFF, 8'h77}) begin
            miscompares++;
            $display("FAIL ena_xfer got done=%b oe=%h out=%h want 000/FF/77", done, uio_oe, uio_out);
        end
        ena = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 3'b001) begin
            miscompares++;
            $display("FAIL ena_done got done=%b want 001", done);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vectors++;
            if ({done, uio_oe, uio_out} !== {3'b000, 8'h00, 8'h77}) begin
                miscompares++;
                $display("FAIL ena_blocked k=%0d got done=%b oe=%h out=%h want 000/00/77",
                         k, done, uio_oe, uio_out);
            end
        end
        req = 3'b000;
        ena = 1'b1;
    endtask

    task automatic test_reset_in_turn();
        do_reset();
        req       = 3'b001;
        req_wr    = 3'b001;
        req_wdata = 24'h000099;
        @(negedge clk);
        req = 3'b000;
        @(negedge clk);
        @(negedge clk);
        req    = 3'b010;
        req_wr = 3'b000;
        @(negedge clk);
        vectors++;
        if ({done, uio_oe, uio_out} !== {3'b000, 8'h00, 8'h99}) begin
            miscompares++;
            $display("FAIL rd_turn got done=%b oe=%h out=%h want 000/00/99", done, uio_oe, uio_out);
        end
        #2;
        rst_n = 1'b0;
        req   = 3'b000;
        #1;
        vectors++;
        if ({done, uio_oe, uio_out, rdata} !== 27'h0) begin
            miscompares++;
            $display("FAIL async_rst got done=%b oe=%h out=%h rdata=%h want all zero",
                     done, uio_oe, uio_out, rdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if ({done, uio_oe} !== {3'b000, 8'h00}) begin
                miscompares++;
                $display("FAIL post_rst k=%0d got done=%b oe=%h want 000/00", k, done, uio_oe);
            end
        end
        req       = 3'b001;
        req_wr    = 3'b001;
        req_wdata = 24'h0000AA;
        @(negedge clk);
        req = 3'b000;
        vectors++;
        if ({done, uio_oe, uio_out} !== {3'b000, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL rst_turn got done=%b oe=%h out=%h want 000/00/00", done, uio_oe, uio_out);
        end
        @(negedge clk);
        vectors++;
        if ({done, uio_oe, uio_out} !== {3'b000, 8'hFF, 8'hAA}) begin
            miscompares++;
            $display("FAIL rst_xfer got done=%b oe=%h out=%h want 000/FF/AA", done, uio_oe, uio_out);
        end
        @(negedge clk);
        vectors++;
        if (done !== 3'b001) begin
            miscompares++;
            $display("FAIL rst_done got done=%b want 001", done);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        req       = 3'b000;
        req_wr    = 3'b000;
        req_wdata = 24'h0;
        uio_in    = 8'h00;
        test_reset();
        test_write_turn();
        test_round_robin();
        test_turnaround();
        test_ena_drop();
        test_reset_in_turn();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
